sync_packet_fifo: RTL and testbench

Synchronous frame-aware FIFO for the switch datapath. It is the successor to the plain sync FIFO core: it keeps the FWFT/non-FWFT modes and fill level, and adds frame boundaries, write-side commit/rollback and overflow discard. The read side only ever sees complete, committed frames. It sits between the MAC receive path and the switch fabric queues.

---
 rtl/sync_fifo_pkg.sv | 7 +
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_packet_fifo.sv | 93 +++++++++
 tb/tb_sync_packet_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: write-side FSM state type and wrap-aware pointer arithmetic for sync_packet_fifo
package sync_fifo_pkg;
  typedef enum logic [1:0] {IDLE, IN_FRAME, DISCARD} wr_state_t;
  function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b, input int unsigned w);
    return (a - b) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: dual-port {last,data} store; ports clk_i/rstn_i, write we_i/waddr_i/wdata_i, read re_i/raddr_i, head_o (async peek), rdata_o (async if P_FWFT else registered on re_i)
module sync_fifo_ram #(
  parameter int P_WIDTH = 9,
  parameter int P_ADDR_WIDTH = 4,
  parameter int P_FWFT = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    we_i,
  input  logic [P_ADDR_WIDTH-1:0] waddr_i,
  input  logic [P_WIDTH-1:0]      wdata_i,
  input  logic                    re_i,
  input  logic [P_ADDR_WIDTH-1:0] raddr_i,
  output logic [P_WIDTH-1:0]      head_o,
  output logic [P_WIDTH-1:0]      rdata_o
);
  logic [P_WIDTH-1:0] mem [2**P_ADDR_WIDTH];
  logic [P_WIDTH-1:0] rd_q;
  always_ff @(posedge clk_i)
    if (we_i) mem[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rd_q <= '0;
    else if (re_i) rd_q <= head_o;
  assign head_o = mem[raddr_i];
  assign rdata_o = (P_FWFT != 0) ? head_o : rd_q;
endmodule

// File: rtl/sync_packet_fifo.sv
// sync_packet_fifo: frame-aware sync FIFO with commit/rollback and overflow discard; write wr_i/data_i/wr_last_i/wr_drop_i, read rd_i -> data_o/rd_last_o, status empty_o/full_o/fill_level_o/frame_count_o/drop_o
module sync_packet_fifo
  import sync_fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4,
  parameter int P_FWFT = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wr_i,
  input  logic [P_DATA_WIDTH-1:0] data_i,
  input  logic                    wr_last_i,
  input  logic                    wr_drop_i,
  input  logic                    rd_i,
  output logic [P_DATA_WIDTH-1:0] data_o,
  output logic                    rd_last_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [P_ADDR_WIDTH:0]   fill_level_o,
  output logic [P_ADDR_WIDTH:0]   frame_count_o,
  output logic                    drop_o
);
  localparam int unsigned PW = P_ADDR_WIDTH + 1;
  localparam logic [P_ADDR_WIDTH:0] DEPTH = {1'b1, {P_ADDR_WIDTH{1'b0}}};
  wr_state_t state_q, state_d;
  logic [P_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, frame_cnt_q;
  logic drop_q, drop_d, we, commit, pop, pop_last;
  logic [P_DATA_WIDTH:0] head, rd_word;
  sync_fifo_ram #(.P_WIDTH(P_DATA_WIDTH + 1), .P_ADDR_WIDTH(P_ADDR_WIDTH), .P_FWFT(P_FWFT)) u_ram (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .we_i(we),
    .waddr_i(wr_ptr_q[P_ADDR_WIDTH-1:0]),
    .wdata_i({wr_last_i, data_i}),
    .re_i(pop),
    .raddr_i(rd_ptr_q[P_ADDR_WIDTH-1:0]),
    .head_o(head),
    .rdata_o(rd_word)
  );
  assign fill_level_o = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
  assign full_o = fill_level_o == DEPTH;
  assign empty_o = rd_ptr_q == cmt_ptr_q;
  assign pop = rd_i && !empty_o;
  assign pop_last = pop && head[P_DATA_WIDTH];
  assign commit = we && wr_last_i;
  assign frame_count_o = frame_cnt_q;
  assign drop_o = drop_q;
  assign {rd_last_o, data_o} = (P_FWFT != 0 && empty_o) ? {(P_DATA_WIDTH + 1){1'b0}} : rd_word;
  // Overflow rewinds wr_ptr to the last commit so a partial frame never consumes space.
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    drop_d = 1'b0;
    we = 1'b0;
    if (state_q == DISCARD) begin
      if (wr_drop_i || (wr_i && wr_last_i)) begin
        state_d = IDLE;
        drop_d = 1'b1;
      end
    end else if (wr_drop_i) begin
      wr_ptr_d = cmt_ptr_q;
      state_d = IDLE;
      drop_d = wr_i || state_q == IN_FRAME;
    end else if (wr_i && full_o) begin
      wr_ptr_d = cmt_ptr_q;
      state_d = wr_last_i ? IDLE : DISCARD;
      drop_d = wr_last_i;
    end else if (wr_i) begin
      we = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      cmt_ptr_d = wr_last_i ? wr_ptr_d : cmt_ptr_q;
      state_d = wr_last_i ? IDLE : IN_FRAME;
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      frame_cnt_q <= frame_cnt_q + PW'(commit) - PW'(pop_last);
      drop_q <= drop_d;
    end
endmodule

// File: tb/tb_sync_packet_fifo.sv
// tb_sync_packet_fifo: drives FWFT and registered-read instances with shared stimulus, checks both against a queue model plus literal checkpoints
module tb_sync_packet_fifo;
  logic clk = 0, rstn = 0, wr = 0, last = 0, drop = 0, rd = 0;
  logic [7:0] din = 0;
  logic [7:0] d_a, d_b;
  logic l_a, l_b, e_a, e_b, f_a, f_b, dr_a, dr_b;
  logic [4:0] fl_a, fl_b, fc_a, fc_b;
  int n_chk = 0, n_fail = 0;
  logic [8:0] cq[$];
  logic [8:0] pq[$];
  logic [8:0] nf_q = 0;
  bit disc = 0, m_drop = 0;
  always #5 clk = ~clk;
  sync_packet_fifo #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .wr_i(wr), .data_i(din), .wr_last_i(last), .wr_drop_i(drop), .rd_i(rd),
    .data_o(d_a), .rd_last_o(l_a), .empty_o(e_a), .full_o(f_a), .fill_level_o(fl_a),
    .frame_count_o(fc_a), .drop_o(dr_a));
  sync_packet_fifo #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .wr_i(wr), .data_i(din), .wr_last_i(last), .wr_drop_i(drop), .rd_i(rd),
    .data_o(d_b), .rd_last_o(l_b), .empty_o(e_b), .full_o(f_b), .fill_level_o(fl_b),
    .frame_count_o(fc_b), .drop_o(dr_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit w, input logic [7:0] d, input bit l, input bit dp, input bit r);
    wr = w;
    din = d;
    last = l;
    drop = dp;
    rd = r;
    @(posedge clk);
    @(negedge clk);
  endtask
  // Model: committed words queue, pending (uncommitted) words, discard flag.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      cq.delete();
      pq.delete();
      disc = 0;
      m_drop = 0;
      nf_q = 0;
    end else begin
      bit full_now;
      full_now = (cq.size() + pq.size()) == 16;
      m_drop = 0;
      if (rd && cq.size() > 0) nf_q = cq.pop_front();
      if (disc) begin
        if (drop || (wr && last)) begin
          disc = 0;
          m_drop = 1;
        end
      end else if (drop) begin
        m_drop = wr || pq.size() > 0;
        pq.delete();
      end else if (wr && full_now) begin
        pq.delete();
        if (last) m_drop = 1;
        else disc = 1;
      end else if (wr) begin
        pq.push_back({last, din});
        if (last) begin
          cq = {cq, pq};
          pq.delete();
        end
      end
    end
  end
  initial forever begin
    int fc, fill;
    @(negedge clk);
    fc = 0;
    foreach (cq[i]) fc += int'(cq[i][8]);
    fill = cq.size() + pq.size();
    chk("empty_a", e_a, cq.size() == 0);
    chk("empty_b", e_b, cq.size() == 0);
    chk("full_a", f_a, fill == 16);
    chk("full_b", f_b, fill == 16);
    chk("fill_a", fl_a, fill);
    chk("fill_b", fl_b, fill);
    chk("fcount_a", fc_a, fc);
    chk("fcount_b", fc_b, fc);
    chk("drop_a", dr_a, m_drop);
    chk("drop_b", dr_b, m_drop);
    if (cq.size() > 0) chk("fwft_word", {l_a, d_a}, cq[0]);
    chk("reg_word", {l_b, d_b}, nf_q);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty", e_a, 1);
    chk("rst_fill", fl_a, 0);
    chk("rst_full", f_a, 0);
    chk("rst_data_b", {l_b, d_b}, 0);
    rstn = 1;
    step(1, 8'hA1, 0, 0, 0);
    chk("t1_empty_a1", e_a, 1);
    step(1, 8'hA2, 0, 0, 0);
    chk("t1_empty_a2", e_a, 1);
    step(1, 8'hA3, 1, 0, 0);
    chk("t1_empty_a3", e_a, 0);
    chk("t1_fcount", fc_a, 1);
    chk("t1_fill", fl_a, 3);
    chk("t1_head", {l_a, d_a}, 9'h0A1);
    step(0, 0, 0, 0, 1);
    chk("t1_regrd1", {l_b, d_b}, 9'h0A1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_regrd3", {l_b, d_b}, 9'h1A3);
    chk("t1_fcount0", fc_a, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    chk("t2_fill4", fl_a, 4);
    step(0, 0, 0, 1, 0);
    chk("t2_fill0", fl_a, 0);
    chk("t2_drop", dr_a, 1);
    chk("t2_empty", e_a, 1);
    step(0, 0, 0, 0, 0);
    chk("t2_drop_off", dr_a, 0);
    step(0, 0, 0, 1, 0);
    chk("t2_idle_drop", dr_a, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 8'(i), i == 20, 0, 0);
      if (i == 16) begin
        chk("t3_full16", f_a, 1);
        chk("t3_fill16", fl_a, 16);
      end
      if (i == 17) begin
        chk("t3_fill17", fl_a, 0);
        chk("t3_drop17", dr_a, 0);
      end
      if (i == 20) begin
        chk("t3_drop20", dr_a, 1);
        chk("t3_empty20", e_a, 1);
      end
    end
    for (int i = 1; i <= 10; i++) step(1, 8'h40 + 8'(i), i == 10, 0, 0);
    chk("t4_f0_fill", fl_a, 10);
    for (int i = 1; i <= 7; i++) step(1, 8'h60 + 8'(i), i == 7, 0, 0);
    chk("t4_fill", fl_a, 10);
    chk("t4_drop", dr_a, 1);
    chk("t4_fcount1", fc_a, 1);
    for (int i = 1; i <= 10; i++) step(0, 0, 0, 0, 1);
    chk("t4_lastword", {l_b, d_b}, 9'h14A);
    chk("t4_fcount0", fc_a, 0);
    for (int i = 1; i <= 3; i++) step(1, 8'h80 + 8'(i), i == 3, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 8'h90 + 8'(i), i == 3, 0, 1);
    chk("t5_fcount_a", fc_a, 1);
    chk("t5_fcount_b", fc_b, 1);
    chk("t5_regrd", {l_b, d_b}, 9'h183);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 1);
    chk("t5_f2_last", {l_b, d_b}, 9'h193);
    for (int i = 1; i <= 2; i++) step(1, 8'hB0 + 8'(i), i == 2, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
    wr = 0;
    last = 0;
    drop = 0;
    rd = 0;
    #2 rstn = 0;
    #1;
    chk("t6_empty", e_a, 1);
    chk("t6_fill_a", fl_a, 0);
    chk("t6_fill_b", fl_b, 0);
    chk("t6_fcount", fc_a, 0);
    chk("t6_full", f_a, 0);
    chk("t6_data_a", {l_a, d_a}, 0);
    chk("t6_data_b", {l_b, d_b}, 0);
    @(negedge clk);
    rstn = 1;
    step(1, 8'hD1, 0, 0, 0);
    step(1, 8'hD2, 1, 0, 0);
    chk("t6_new_fill", fl_a, 2);
    chk("t6_new_head", {l_a, d_a}, 9'h0D1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_new_last", {l_b, d_b}, 9'h1D2);
    chk("t6_new_fcount", fc_a, 0);
    step(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
